// File: rtl/enigma_seq.sv
// Rotor-pipeline sequencer: configures N_ROT external rotor stages, threads each character
// through them in encrypt or decrypt order, and steps the rotor odometer after every letter.
module enigma_seq #(
  parameter int unsigned N_ROT   = 3,
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned ALPHA   = 26
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cfg_valid,
  output logic                 cfg_ready,
  input  logic [1:0]           cfg_sel,
  input  logic [31:0]          cfg_offset,
  input  logic [31:0]          cfg_delay,
  input  logic [8*ALPHA-1:0]   cfg_wiring,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [7:0]           in_char,
  input  logic                 dec,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [7:0]           out_char,
  output logic                 err,
  output logic                 busy,
  output logic [N_ROT-1:0]     rot_set,
  output logic [N_ROT-1:0]     rot_en,
  output logic [N_ROT-1:0]     rot_valid,
  output logic [7:0]           rot_din,
  output logic [31:0]          rot_offset,
  output logic [31:0]          rot_delay,
  output logic [8*ALPHA-1:0]   rot_wiring,
  output logic                 rot_dec,
  input  logic [8*N_ROT-1:0]   rot_dout,
  input  logic [N_ROT-1:0]     rot_done
);

  localparam int unsigned SW = (N_ROT > 1) ? $clog2(N_ROT) : 1;
  localparam int unsigned CW = $clog2(ALPHA);
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {StIdle, StCfg, StIssue, StWait, StStep, StOut} state_e;

  state_e               state_q, state_d;
  logic [N_ROT-1:0]     mask_q, mask_d;
  logic [CW-1:0]        cnt_q [N_ROT];
  logic [CW-1:0]        cnt_d [N_ROT];
  logic [TW-1:0]        tmo_q, tmo_d;
  logic [SW-1:0]        stage_q, stage_d;
  logic [7:0]           char_q, char_d;
  logic [7:0]           din_q, din_d;
  logic                 dec_q, dec_d;
  logic [1:0]           sel_q, sel_d;
  logic [31:0]          off_q, off_d;
  logic [31:0]          dly_q, dly_d;
  logic [8*ALPHA-1:0]   wir_q, wir_d;

  logic                 stage_done;
  logic [7:0]           stage_dout;
  logic                 last_stage;
  logic                 carry;

  always_comb begin
    stage_done = 1'b0;
    stage_dout = 8'h00;
    for (int k = 0; k < int'(N_ROT); k++) begin
      if (stage_q == SW'(k)) begin
        stage_done = rot_done[k];
        stage_dout = rot_dout[8*k +: 8];
      end
    end
  end

  assign last_stage = dec_q ? (stage_q == '0) : (stage_q == SW'(N_ROT - 1));

  assign busy       = (state_q != StIdle);
  assign cfg_ready  = (state_q == StIdle);
  assign out_char   = char_q;
  assign rot_dec    = dec_q;
  assign rot_din    = din_d;
  assign rot_offset = off_q;
  assign rot_delay  = dly_q;
  assign rot_wiring = wir_q;

  always_comb begin
    state_d   = state_q;
    mask_d    = mask_q;
    cnt_d     = cnt_q;
    tmo_d     = tmo_q;
    stage_d   = stage_q;
    char_d    = char_q;
    din_d     = din_q;
    dec_d     = dec_q;
    sel_d     = sel_q;
    off_d     = off_q;
    dly_d     = dly_q;
    wir_d     = wir_q;
    carry     = 1'b0;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    err       = 1'b0;
    rot_set   = '0;
    rot_en    = '0;
    rot_valid = '0;

    unique case (state_q)
      StIdle: begin
        // A pending config wins; the character waits for a later IDLE cycle.
        in_ready = (&mask_q) && !cfg_valid;
        if (cfg_valid) begin
          sel_d   = cfg_sel;
          off_d   = cfg_offset;
          dly_d   = cfg_delay;
          wir_d   = cfg_wiring;
          state_d = StCfg;
        end else if (in_valid && (&mask_q)) begin
          char_d = in_char;
          dec_d  = dec;
          if (in_char >= 8'h41 && in_char <= 8'h5A) begin
            stage_d = dec ? SW'(N_ROT - 1) : '0;
            state_d = StIssue;
          end else begin
            state_d = StOut;
          end
        end
      end
      StCfg: begin
        if (int'(sel_q) < int'(N_ROT)) begin
          for (int k = 0; k < int'(N_ROT); k++) begin
            if (int'(sel_q) == k) begin
              rot_set[k] = 1'b1;
              mask_d[k]  = 1'b1;
              cnt_d[k]   = '0;
            end
          end
        end else begin
          err = 1'b1;
        end
        state_d = StIdle;
      end
      StIssue: begin
        for (int k = 0; k < int'(N_ROT); k++) begin
          if (stage_q == SW'(k)) rot_valid[k] = 1'b1;
        end
        din_d   = char_q;
        tmo_d   = '0;
        state_d = StWait;
      end
      StWait: begin
        if (stage_done) begin
          char_d = stage_dout;
          if (last_stage) begin
            state_d = StStep;
          end else begin
            stage_d = dec_q ? (stage_q - SW'(1)) : (stage_q + SW'(1));
            state_d = StIssue;
          end
        end else if (tmo_q == TW'(TIMEOUT - 1)) begin
          err     = 1'b1;
          char_d  = 8'h3F;
          state_d = StOut;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      StStep: begin
        // Odometer: each wrap carries into the next rotor within the same cycle.
        carry = 1'b1;
        for (int k = 0; k < int'(N_ROT); k++) begin
          if (carry) begin
            rot_en[k] = 1'b1;
            if (cnt_q[k] == CW'(ALPHA - 1)) begin
              cnt_d[k] = '0;
            end else begin
              cnt_d[k] = cnt_q[k] + CW'(1);
              carry    = 1'b0;
            end
          end
        end
        state_d = StOut;
      end
      StOut: begin
        out_valid = 1'b1;
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      mask_q  <= '0;
      cnt_q   <= '{default: '0};
      tmo_q   <= '0;
      stage_q <= '0;
      char_q  <= 8'h00;
      din_q   <= 8'h00;
      dec_q   <= 1'b0;
      sel_q   <= 2'd0;
      off_q   <= 32'd0;
      dly_q   <= 32'd0;
      wir_q   <= '0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
      stage_q <= stage_d;
      char_q  <= char_d;
      din_q   <= din_d;
      dec_q   <= dec_d;
      sel_q   <= sel_d;
      off_q   <= off_d;
      dly_q   <= dly_d;
      wir_q   <= wir_d;
    end
  end

endmodule

// File: doc/enigma_seq.md
ENIGMA_SEQ -- requirements
Module: enigma_seq

Interface
REQ-001 SHALL have parameters: N_ROT, 3, number of rotor stages; TIMEOUT, 64, maximum cycles to wait for a stage's rot_done; ALPHA, 26, rotor positions per revolution.
REQ-002 SHALL provide ports:
- clk  in  1  single clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- cfg_valid  in  1  configuration request
- cfg_ready  out  1  configuration accepted when high with cfg_valid
- cfg_sel  in  2  target rotor (0..N_ROT-1)
- cfg_offset  in  32  rotor step offset
- cfg_delay  in  32  rotor delay count
- cfg_wiring  in  208  26 x 8-bit wiring table
- in_valid  in  1  character request
- in_ready  out  1  character accepted when high with in_valid
- in_char  in  8  ASCII character
- dec  in  1  0 = encrypt, 1 = decrypt; sampled at character acceptance
- out_valid  out  1  result available
- out_ready  in  1  result consumed when high with out_valid
- out_char  out  8  result character
- err  out  1  one-cycle error pulse
- busy  out  1  high whenever state is not IDLE
- rot_set  out  N_ROT  per-rotor configuration strobe
- rot_en  out  N_ROT  per-rotor step strobe
- rot_valid  out  N_ROT  per-rotor input strobe
- rot_din  out  8  shared rotor input character
- rot_offset, rot_delay, rot_wiring  out  32/32/208  shared configuration bus
- rot_dec  out  1  latched mode to all rotors
- rot_dout  in  8*N_ROT  rotor outputs; stage k at bits [8k+7:8k]
- rot_done  in  N_ROT  per-rotor completion

Function
REQ-003 SHALL implement FSM states IDLE, CFG, ISSUE, WAIT, STEP, OUT.
REQ-004 SHALL hold a configured mask; in_ready SHALL be 1 only in IDLE with all N_ROT mask bits set; cfg_ready SHALL be 1 only in IDLE.
REQ-005 In IDLE, cfg_valid SHALL take priority over in_valid when both are high; the character stays pending (in_ready forced 0 that cycle).
REQ-006 On cfg accept: latch fields; go to CFG; in CFG, drive rot_set[cfg_sel] = 1 for exactly one cycle with the latched offset/delay/wiring on the rot_* bus; set mask bit; clear step counter of that rotor; return to IDLE.
REQ-007 A cfg accept with cfg_sel >= N_ROT SHALL pulse err for one cycle, drive no rot_set, leave the mask unchanged, and return to IDLE.
REQ-008 On char accept: latch in_char and dec. Characters outside 8'h41..8'h5A SHALL bypass the rotors and go directly to OUT unchanged, with no stepping.
REQ-009 Stage order SHALL be 0,1,...,N_ROT-1 when encrypting and N_ROT-1,...,0 when decrypting; rot_dec SHALL equal the latched dec from acceptance until return to IDLE.
REQ-010 ISSUE SHALL drive rot_valid[stage] = 1 for one cycle with rot_din = the current character, then enter WAIT.
REQ-011 WAIT SHALL ignore rot_done in the ISSUE cycle and sample it from the next cycle on. When rot_done[stage] = 1, capture rot_dout of that stage as the current character, then go to ISSUE for the next stage, or to STEP after the last stage.
REQ-012 The WAIT timeout counter SHALL clear on ISSUE. After TIMEOUT cycles in WAIT without rot_done: pulse err, set out_char = 8'h3F, skip STEP, go to OUT.
REQ-013 STEP SHALL last one cycle. It pulses rot_en[0] and increments step counter 0 (mod ALPHA). When counter k wraps 25->0, rot_en[k+1] SHALL pulse in the same cycle and counter k+1 increments, cascading odometer-style. A wrap of the last rotor has no further effect.
REQ-014 OUT SHALL hold out_valid and out_char stable until out_ready; the state returns to IDLE in the cycle after the handshake. No new input is accepted while out_valid = 1.
REQ-015 Outside the cycles defined above, rot_set, rot_en and rot_valid SHALL be 0. rot_din SHALL hold its last value.
REQ-016 End-to-end latency, all done immediately: 2*N_ROT + 1 cycles from accept to out_valid.

Reset
REQ-017 When reset = 1 at a clock edge, the block SHALL enter IDLE; clear the mask, step counters and timeout counter; and drive out_valid = 0, out_char = 0, err = 0, busy = 0, cfg_ready = 1, in_ready = 0, rot_* strobes = 0, rot_din = 0, rot_dec = 0.
REQ-018 Reset in any state, including mid-WAIT or OUT, SHALL abandon the character with no output.

Verification
REQ-019 Configure rotors 0..2 with identity wiring "A..Z", offset 0, delay 1; send 'H' -> out_char = 'H', exactly one rot_valid pulse per stage in order 0,1,2, one rot_en[0] pulse.
REQ-020 Send 26 valid characters -> on the 26th STEP, rot_en[0] and rot_en[1] pulse in the same cycle; counter 0 reads 0 and counter 1 reads 1.
REQ-021 dec = 1, send 'Q' -> rot_valid order 2,1,0, and rot_dec = 1 throughout.
REQ-022 Hold rot_done = 0 -> err pulses exactly TIMEOUT cycles after ISSUE; out_char = 8'h3F; no rot_en pulse.
REQ-023 cfg_valid and in_valid high in the same IDLE cycle -> config is taken first and the char is accepted afterwards; cfg_sel = 3 -> err pulse, mask unchanged.
REQ-024 Assert reset during WAIT -> next cycle all outputs equal the REQ-017 values and in_ready = 0 until reconfigured; send ' ' -> output ' ' with no rot_valid.
